five_bit_serial_subtractor: RTL and testbench

Bit-serial 5-bit subtractor: the inverse datapath to the lab's 5-bit ripple adder. It computes D = A − B − Bi one bit per clock through a single full-subtractor cell and a registered borrow. It sits beside the adder in the lab6 arithmetic set and trades area for latency. A start/busy/done handshake lets a controller launch one operation at a time.

---
 rtl/five_bit_sub_pkg.sv | 13 +
 rtl/five_bit_serial_subtractor_cell.sv | 13 +
 rtl/five_bit_serial_subtractor.sv | 98 +++++++++
 tb/tb_five_bit_serial_subtractor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/five_bit_sub_pkg.sv
// Shared constants and FSM state type for the bit-serial 5-bit subtractor.
package five_bit_sub_pkg;

    localparam int SUB_W = 5;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/five_bit_serial_subtractor_cell.sv
// Single-bit full subtractor: D = A - B - Bi with borrow-out Bo.
module oneBitFullSubtractor (
    input  logic A,
    input  logic B,
    input  logic Bi,
    output logic Bo,
    output logic D
);

    assign D  = A ^ B ^ Bi;
    assign Bo = (~A & B) | (~(A ^ B) & Bi);

endmodule

// File: rtl/five_bit_serial_subtractor.sv
// Bit-serial 5-bit subtractor: one bit per clock through one cell,
// with a start/busy/done handshake and registered result.
module five_bit_serial_subtractor
    import five_bit_sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SUB_W-1:0] A,
    input  logic [SUB_W-1:0] B,
    input  logic             Bi,
    output logic             busy,
    output logic             done,
    output logic [SUB_W-1:0] D,
    output logic             Bo
);

    state_t             state_q;
    logic [SUB_W-1:0]   a_sr_q;
    logic [SUB_W-1:0]   b_sr_q;
    logic [SUB_W-1:0]   d_sr_q;
    logic [SUB_W-1:0]   d_sr_d;
    logic [SUB_W-1:0]   d_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               borrow_q;
    logic               bo_q;
    logic               busy_q;
    logic               done_q;
    logic               cell_d;
    logic               cell_bo;

    oneBitFullSubtractor u_cell (
        .A  (a_sr_q[0]),
        .B  (b_sr_q[0]),
        .Bi (borrow_q),
        .Bo (cell_bo),
        .D  (cell_d)
    );

    // New diff bit enters at the MSB so bit 0 ends up at the LSB after 5 shifts.
    assign d_sr_d = {cell_d, d_sr_q[SUB_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_sr_q   <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q   <= A;
                        b_sr_q   <= B;
                        borrow_q <= Bi;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    d_sr_q   <= d_sr_d;
                    borrow_q <= cell_bo;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SUB_W - 1)) begin
                        d_q     <= d_sr_d;
                        bo_q    <= cell_bo;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bo   = bo_q;

endmodule

// File: tb/tb_five_bit_serial_subtractor.sv
// Directed bench for the bit-serial 5-bit subtractor: vector table
// plus hand-written handshake, abort and back-to-back sequences.
module tb_five_bit_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] A;
    logic [4:0] B;
    logic       Bi;
    logic       busy;
    logic       done;
    logic [4:0] D;
    logic       Bo;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    five_bit_serial_subtractor dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bi    (Bi),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bo    (Bo)
    );

    always @(negedge clk) if (done) done_seen++;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic       bi;
        logic [4:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, accept it, then check busy/done/result timing.
    task automatic run_op(input logic [4:0] a, input logic [4:0] b,
                          input logic bi, input logic [4:0] ed,
                          input logic ebo, input string tag);
        A = a; B = b; Bi = bi; start = 1'b1;
        tick();
        start = 1'b0; A = 5'h1f; B = 5'h1f; Bi = 1'b1;
        chk({tag, ".busy_accept"}, busy, 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k < 5) begin
                if (busy !== 1'b1 || done !== 1'b0)
                    chk({tag, ".shift_flags"}, {busy, done}, 2'b10);
            end else begin
                chk({tag, ".done"}, done, 1);
                chk({tag, ".busy_done"}, busy, 0);
                chk({tag, ".D"}, D, ed);
                chk({tag, ".Bo"}, Bo, ebo);
            end
        end
        tick();
        chk({tag, ".done_drop"}, done, 0);
        chk({tag, ".D_hold"}, D, ed);
    endtask

    initial begin
        int base;
        vecs[0] = '{5'd13, 5'd6,  1'b0, 5'd7,  1'b0};
        vecs[1] = '{5'd3,  5'd9,  1'b0, 5'd26, 1'b1};
        vecs[2] = '{5'd0,  5'd0,  1'b1, 5'd31, 1'b1};
        vecs[3] = '{5'd31, 5'd0,  1'b0, 5'd31, 1'b0};
        vecs[4] = '{5'd10, 5'd10, 1'b0, 5'd0,  1'b0};
        vecs[5] = '{5'd16, 5'd15, 1'b1, 5'd0,  1'b0};
        vecs[6] = '{5'd5,  5'd5,  1'b1, 5'd31, 1'b1};
        vecs[7] = '{5'd31, 5'd31, 1'b1, 5'd31, 1'b1};
        vecs[8] = '{5'd7,  5'd1,  1'b1, 5'd5,  1'b0};
        vecs[9] = '{5'd0,  5'd31, 1'b0, 5'd1,  1'b1};

        rst = 1'b1; start = 1'b1; A = 5'd9; B = 5'd2; Bi = 1'b0;
        tick();
        tick();
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.D", D, 0);
        chk("reset.Bo", Bo, 0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("idle.busy", busy, 0);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].bi,
                   vecs[i].d, vecs[i].bo, $sformatf("vec%0d", i));

        // Second start while busy must be ignored.
        tick();
        base = done_seen;
        A = 5'd20; B = 5'd5; Bi = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        A = 5'd1; B = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        chk("ignore.dones", done_seen - base, 1);
        chk("ignore.D", D, 15);
        chk("ignore.Bo", Bo, 0);
        chk("ignore.busy", busy, 0);

        // Reset in the third SHIFT cycle aborts without a done.
        base = done_seen;
        A = 5'd13; B = 5'd6; Bi = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.D", D, 0);
        chk("abort.Bo", Bo, 0);
        repeat (6) tick();
        chk("abort.dones", done_seen - base, 0);
        run_op(5'd10, 5'd10, 1'b0, 5'd0, 1'b0, "post_abort");

        // Back-to-back: start held high through DONE.
        A = 5'd8; B = 5'd1; Bi = 1'b0; start = 1'b1;
        tick();
        A = 5'd1; B = 5'd8;
        repeat (5) tick();
        chk("b2b.done1", done, 1);
        chk("b2b.D1", D, 7);
        chk("b2b.Bo1", Bo, 0);
        tick();
        start = 1'b0;
        chk("b2b.busy2", busy, 1);
        chk("b2b.done_gap", done, 0);
        repeat (5) tick();
        chk("b2b.done2", done, 1);
        chk("b2b.D2", D, 25);
        chk("b2b.Bo2", Bo, 1);
        tick();
        chk("b2b.done_drop", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
